uart_result_sender: RTL

//  Transmit-side sequencer for the host UART link. It runs in the command FSM's

---
 rtl/uart_result_sender.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_result_sender.sv
// Transmit-side sequencer: fetches result bytes from the output RAM and feeds them
// one frame at a time to the UART, reporting completed bytes and a done flag.
module uart_result_sender #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_send,
    input  logic [ADDR_W-1:0] input_len,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_dv,
    output logic [ADDR_W-1:0] byte_count,
    output logic              send_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_RAM = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_WAIT_TX  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [1:0]        lat_q, lat_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        count_d = count_q;
        byte_d  = byte_q;
        lat_d   = lat_q;
        busy_d  = tx_busy;

        case (state_q)
            S_IDLE: begin
                if (start_send) begin
                    len_d   = input_len;
                    addr_d  = '0;
                    count_d = '0;
                    state_d = (input_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                // The fetch cycle itself is the first cycle of RAM latency.
                lat_d   = 2'd1;
                state_d = start_send ? S_WAIT_RAM : S_IDLE;
            end
            S_WAIT_RAM: begin
                if (!start_send) begin
                    state_d = S_IDLE;
                end else if (lat_q >= LAT_LAST) begin
                    byte_d  = ram_rdata;
                    state_d = S_LOAD;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_LOAD: begin
                // Registered busy gives the UART a full cycle to settle after a release.
                if (!start_send) begin
                    state_d = S_IDLE;
                end else if (!busy_q) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    count_d = count_q + ADDR_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    if (!start_send) begin
                        state_d = S_IDLE;
                    end else if (count_q + ADDR_W'(1) == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (!start_send) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            byte_q  <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            byte_q  <= byte_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
        end
    end

    assign ram_addr   = addr_q;
    assign ram_rd_en  = (state_q == S_FETCH);
    assign tx_byte    = byte_q;
    assign tx_dv      = (state_q == S_SEND);
    assign byte_count = count_q;
    assign send_done  = (state_q == S_DONE);

endmodule
